sram_block_rmw_cache: RTL and testbench

Parametrised two-port block SRAM for the cache path.
- Each entry holds one block of ELEMENTS_PER_BLOCK elements.
- Adds per-element write masking via internal read-modify-write (RMW), registered reads with valid strobes, and a port-conflict arbiter.
- A post-reset init sequencer fills every entry with INIT_VALUE.
- Sits between the cache controller and the inferred RAM; replaces the fixed-width always-enabled dual-port wrapper.

---
 rtl/sram_block_rmw_cache.sv | 236 +++++++++++++++++++++++
 tb/tb_sram_block_rmw_cache.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_block_rmw_cache.sv
// Two-port block SRAM with per-element write masking (read-modify-write), post-reset init fill
// and same-address arbitration. Define SRAM_PARITY_EN for per-element even parity checking.
module sram_block_rmw_cache #(
   parameter int unsigned ELEMENT_WIDTH      = 32,
   parameter int unsigned ELEMENTS_PER_BLOCK = 4,
   parameter int unsigned DEPTH              = 64,
   parameter int unsigned LG_DEPTH           = 6,
   parameter logic [ELEMENT_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                                        clk,
   input  logic                                        reset,
   output logic                                        io_init_done,
`ifdef SRAM_PARITY_EN
   input  logic                                        io_perr_inject,
   output logic [ELEMENTS_PER_BLOCK-1:0]               io_perr_0,
   output logic [ELEMENTS_PER_BLOCK-1:0]               io_perr_1,
`endif
   input  logic                                        io_req_0,
   input  logic                                        io_we_0,
   input  logic [LG_DEPTH-1:0]                         io_addr_0,
   input  logic [ELEMENT_WIDTH*ELEMENTS_PER_BLOCK-1:0] io_din_0,
   input  logic [ELEMENTS_PER_BLOCK-1:0]               io_wmask_0,
   output logic                                        io_ready_0,
   output logic [ELEMENT_WIDTH*ELEMENTS_PER_BLOCK-1:0] io_dout_0,
   output logic                                        io_valid_0,
   output logic                                        io_conflict_0,
   input  logic                                        io_req_1,
   input  logic                                        io_we_1,
   input  logic [LG_DEPTH-1:0]                         io_addr_1,
   input  logic [ELEMENT_WIDTH*ELEMENTS_PER_BLOCK-1:0] io_din_1,
   input  logic [ELEMENTS_PER_BLOCK-1:0]               io_wmask_1,
   output logic                                        io_ready_1,
   output logic [ELEMENT_WIDTH*ELEMENTS_PER_BLOCK-1:0] io_dout_1,
   output logic                                        io_valid_1,
   output logic                                        io_conflict_1
);

   localparam int unsigned EW = ELEMENT_WIDTH;
   localparam int unsigned E  = ELEMENTS_PER_BLOCK;
   localparam int unsigned W  = EW * E;
   localparam logic [LG_DEPTH-1:0] LAST_ADDR = LG_DEPTH'(DEPTH - 1);
   localparam logic [LG_DEPTH:0]   DEPTH_L   = (LG_DEPTH + 1)'(DEPTH);
   localparam logic [W-1:0]        INIT_BLOCK = {E{INIT_VALUE}};

   typedef enum logic [1:0] {StInit, StIdle, StMerge} state_t;

   state_t                    state_q, state_d;
   logic [LG_DEPTH-1:0]       cnt_q, cnt_d;
   logic                      sel_q, sel_d;
   logic                      pend_q, pend_d;
   logic                      init_done_q;
   logic [1:0][W-1:0]         dout_q;
   logic [1:0]                valid_q;
   logic                      conflict1_q;

   logic [W-1:0]              mem [DEPTH];
   logic [1:0][LG_DEPTH-1:0]  m_addr_q;
   logic [1:0][W-1:0]         m_din_q;
   logic [1:0][W-1:0]         m_old_q;
   logic [1:0][E-1:0]         m_mask_q;

   logic [1:0]                req, we;
   logic [1:0][LG_DEPTH-1:0]  addr;
   logic [1:0][W-1:0]         din;
   logic [1:0][E-1:0]         wmask;

   logic                      idle, drop1;
   logic [1:0]                acc, in_range, rd_acc, wr_full, wr_part;
   logic [1:0][W-1:0]         rd_data;
   logic [W-1:0]              merged;

   assign req   = {io_req_1, io_req_0};
   assign we    = {io_we_1, io_we_0};
   assign addr  = {io_addr_1, io_addr_0};
   assign din   = {io_din_1, io_din_0};
   assign wmask = {io_wmask_1, io_wmask_0};

   always_comb begin
      idle  = (state_q == StIdle);
      // Port 0 wins any same-address pairing that involves a write.
      drop1 = idle && req[0] && req[1] && (addr[0] == addr[1]) && (we[0] || we[1]);
      acc[0] = idle && req[0];
      acc[1] = idle && req[1] && !drop1;
      for (int p = 0; p < 2; p++) begin
         in_range[p] = ({1'b0, addr[p]} < DEPTH_L);
         rd_acc[p]   = acc[p] && !we[p];
         wr_full[p]  = acc[p] && we[p] && in_range[p] && (&wmask[p]);
         wr_part[p]  = acc[p] && we[p] && in_range[p] && !(&wmask[p]) && (|wmask[p]);
         rd_data[p]  = in_range[p] ? mem[addr[p]] : '0;
      end
      for (int e = 0; e < E; e++) begin
         merged[e*EW +: EW] = m_mask_q[sel_q][e] ? m_din_q[sel_q][e*EW +: EW]
                                                 : m_old_q[sel_q][e*EW +: EW];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      pend_d  = pend_q;
      unique case (state_q)
         StInit: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         end
         StIdle: begin
            if (wr_part[0]) begin
               state_d = StMerge;
               sel_d   = 1'b0;
               pend_d  = wr_part[1];
            end else if (wr_part[1]) begin
               state_d = StMerge;
               sel_d   = 1'b1;
               pend_d  = 1'b0;
            end
         end
         StMerge: begin
            // A queued port-1 merge takes a second stall cycle.
            if (pend_q) begin
               sel_d  = 1'b1;
               pend_d = 1'b0;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StInit;
      endcase
   end

`ifdef SRAM_PARITY_EN
   function automatic logic [E-1:0] block_par(input logic [W-1:0] b);
      logic [E-1:0] r;
      for (int e = 0; e < E; e++) r[e] = ^b[e*EW +: EW];
      return r;
   endfunction

   logic [E-1:0]      par_mem [DEPTH];
   logic [1:0]        m_inj_q;
   logic [1:0][E-1:0] perr_q;
   logic [1:0][E-1:0] rd_perr;
   logic [E-1:0]      inj;

   always_comb begin
      inj = E'(io_perr_inject);
      for (int p = 0; p < 2; p++) begin
         rd_perr[p] = in_range[p] ? (par_mem[addr[p]] ^ block_par(rd_data[p])) : '0;
      end
   end

   always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         if (wr_part[p]) m_inj_q[p] <= io_perr_inject;
      end
      if (state_q == StInit) begin
         par_mem[cnt_q] <= block_par(INIT_BLOCK);
      end else if (state_q == StMerge) begin
         par_mem[m_addr_q[sel_q]] <= block_par(merged) ^ E'(m_inj_q[sel_q]);
      end else begin
         if (wr_full[0]) par_mem[addr[0]] <= block_par(din[0]) ^ inj;
         if (wr_full[1]) par_mem[addr[1]] <= block_par(din[1]) ^ inj;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perr_q <= '0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (rd_acc[p]) perr_q[p] <= rd_perr[p];
         end
      end
   end

   assign io_perr_0 = perr_q[0];
   assign io_perr_1 = perr_q[1];
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StInit;
         cnt_q       <= '0;
         sel_q       <= 1'b0;
         pend_q      <= 1'b0;
         init_done_q <= 1'b0;
         dout_q      <= '0;
         valid_q     <= '0;
         conflict1_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sel_q       <= sel_d;
         pend_q      <= pend_d;
         valid_q     <= rd_acc;
         conflict1_q <= drop1;
         if (state_q == StInit && cnt_q == LAST_ADDR) init_done_q <= 1'b1;
         for (int p = 0; p < 2; p++) begin
            if (rd_acc[p]) dout_q[p] <= rd_data[p];
         end
      end
   end

   // Storage and merge operands carry no reset; a reset simply abandons a pending merge.
   always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         if (wr_part[p]) begin
            m_addr_q[p] <= addr[p];
            m_din_q[p]  <= din[p];
            m_mask_q[p] <= wmask[p];
            m_old_q[p]  <= rd_data[p];
         end
      end
      if (state_q == StInit) begin
         mem[cnt_q] <= INIT_BLOCK;
      end else if (state_q == StMerge) begin
         mem[m_addr_q[sel_q]] <= merged;
      end else begin
         if (wr_full[0]) mem[addr[0]] <= din[0];
         if (wr_full[1]) mem[addr[1]] <= din[1];
      end
   end

   assign io_init_done  = init_done_q;
   assign io_ready_0    = idle;
   assign io_ready_1    = idle;
   assign io_dout_0     = dout_q[0];
   assign io_dout_1     = dout_q[1];
   assign io_valid_0    = valid_q[0];
   assign io_valid_1    = valid_q[1];
   assign io_conflict_0 = 1'b0;
   assign io_conflict_1 = conflict1_q;

endmodule

// File: tb/tb_sram_block_rmw_cache.sv
// Scoreboard bench for sram_block_rmw_cache: reference block model, per-port expected-read
// queues popped on io_valid_p, plus arbitration, stall and init-timing checks.
module tb_sram_block_rmw_cache;

   localparam int unsigned EW    = 32;
   localparam int unsigned E     = 4;
   localparam int unsigned DEPTH = 64;
   localparam int unsigned LG    = 6;
   localparam int unsigned W     = EW * E;

   logic          clk = 1'b0;
   logic          reset;
   logic          io_init_done;
   logic          io_req_0, io_we_0, io_req_1, io_we_1;
   logic [LG-1:0] io_addr_0, io_addr_1;
   logic [W-1:0]  io_din_0, io_din_1, io_dout_0, io_dout_1;
   logic [E-1:0]  io_wmask_0, io_wmask_1;
   logic          io_ready_0, io_ready_1, io_valid_0, io_valid_1;
   logic          io_conflict_0, io_conflict_1;
`ifdef SRAM_PARITY_EN
   logic          io_perr_inject;
   logic [E-1:0]  io_perr_0, io_perr_1;
`endif

   int unsigned   n_cmp = 0;
   int unsigned   n_err = 0;
   logic [W-1:0]  model [DEPTH];
   logic [W-1:0]  exp_q0 [$];
   logic [W-1:0]  exp_q1 [$];

   sram_block_rmw_cache dut (
      .clk           (clk),
      .reset         (reset),
      .io_init_done  (io_init_done),
`ifdef SRAM_PARITY_EN
      .io_perr_inject(io_perr_inject),
      .io_perr_0     (io_perr_0),
      .io_perr_1     (io_perr_1),
`endif
      .io_req_0      (io_req_0),
      .io_we_0       (io_we_0),
      .io_addr_0     (io_addr_0),
      .io_din_0      (io_din_0),
      .io_wmask_0    (io_wmask_0),
      .io_ready_0    (io_ready_0),
      .io_dout_0     (io_dout_0),
      .io_valid_0    (io_valid_0),
      .io_conflict_0 (io_conflict_0),
      .io_req_1      (io_req_1),
      .io_we_1       (io_we_1),
      .io_addr_1     (io_addr_1),
      .io_din_1      (io_din_1),
      .io_wmask_1    (io_wmask_1),
      .io_ready_1    (io_ready_1),
      .io_dout_1     (io_dout_1),
      .io_valid_1    (io_valid_1),
      .io_conflict_1 (io_conflict_1)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] d,
                                          input logic [E-1:0] m);
      logic [W-1:0] r = old;
      for (int e = 0; e < E; e++) if (m[e]) r[e*EW +: EW] = d[e*EW +: EW];
      return r;
   endfunction

   function automatic logic is_part(input logic [E-1:0] m);
      return (m != '0) && (m != '1);
   endfunction

   // Read results are matched against the scoreboard whenever the DUT strobes valid.
   always @(posedge clk) begin
      #1;
      if (io_valid_0) begin
         if (exp_q0.size() == 0) check_eq("rd0_unexpected_valid", W'(io_valid_0), '0);
         else check_eq("rd0_data", io_dout_0, exp_q0.pop_front());
      end
      if (io_valid_1) begin
         if (exp_q1.size() == 0) check_eq("rd1_unexpected_valid", W'(io_valid_1), '0);
         else check_eq("rd1_data", io_dout_1, exp_q1.pop_front());
      end
   end

   task automatic op2(input logic r0, input logic w0, input logic [LG-1:0] a0,
                      input logic [W-1:0] d0, input logic [E-1:0] m0,
                      input logic r1, input logic w1, input logic [LG-1:0] a1,
                      input logic [W-1:0] d1, input logic [E-1:0] m1);
      logic         drop;
      int           nm;
      int           guard;
      logic [W-1:0] old0, old1;
      guard = 0;
      while (!io_ready_0 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!io_ready_0) check_eq("ready_timeout", W'(io_ready_0), W'(1));
      drop = r0 && r1 && (a0 == a1) && (w0 || w1);
      nm   = 0;
      old0 = model[a0];
      old1 = model[a1];
      if (r0) begin
         if (!w0) exp_q0.push_back(old0);
         else begin
            model[a0] = merge(old0, d0, m0);
            if (is_part(m0)) nm++;
         end
      end
      if (r1 && !drop) begin
         if (!w1) exp_q1.push_back(old1);
         else begin
            model[a1] = merge(old1, d1, m1);
            if (is_part(m1)) nm++;
         end
      end
      io_req_0 = r0; io_we_0 = w0; io_addr_0 = a0; io_din_0 = d0; io_wmask_0 = m0;
      io_req_1 = r1; io_we_1 = w1; io_addr_1 = a1; io_din_1 = d1; io_wmask_1 = m1;
      @(posedge clk);
      #1;
      check_eq("conflict1", W'(io_conflict_1), W'(drop));
      check_eq("conflict0", W'(io_conflict_0), '0);
      check_eq("valid0_latency", W'(io_valid_0), W'(r0 && !w0));
      check_eq("valid1_latency", W'(io_valid_1), W'(r1 && !w1 && !drop));
      @(negedge clk);
      io_req_0 = 1'b0;
      io_req_1 = 1'b0;
      for (int i = 0; i < nm; i++) begin
         check_eq("merge_ready0_low", W'(io_ready_0), '0);
         check_eq("merge_ready1_low", W'(io_ready_1), '0);
         @(negedge clk);
      end
      check_eq("ready_back", W'(io_ready_0 && io_ready_1), W'(1));
   endtask

   task automatic op1(input int p, input logic w, input logic [LG-1:0] a,
                      input logic [W-1:0] d, input logic [E-1:0] m);
      if (p == 0) op2(1'b1, w, a, d, m, 1'b0, 1'b0, '0, '0, '0);
      else op2(1'b0, 1'b0, '0, '0, '0, 1'b1, w, a, d, m);
   endtask

   task automatic wait_init(input string tag);
      int cycles = 0;
      while (!io_init_done && cycles < 200) begin
         @(posedge clk);
         #1;
         cycles++;
         if (cycles == 10) check_eq({tag, "_ready_during_init"}, W'(io_ready_0), '0);
      end
      io_req_0 = 1'b0;
      check_eq({tag, "_init_cycles"}, W'(cycles), W'(DEPTH));
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] blk_a, blk_b;
      logic         r0, w0, r1, w1;
      logic [LG-1:0] a0, a1;
      logic [E-1:0] m0, m1;
      reset = 1'b1;
      io_req_0 = 1'b0; io_we_0 = 1'b0; io_addr_0 = '0; io_din_0 = '0; io_wmask_0 = '0;
      io_req_1 = 1'b0; io_we_1 = 1'b0; io_addr_1 = '0; io_din_1 = '0; io_wmask_1 = '0;
`ifdef SRAM_PARITY_EN
      io_perr_inject = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check_eq("rst_init_done", W'(io_init_done), '0);
      check_eq("rst_ready", W'(io_ready_0 | io_ready_1), '0);
      check_eq("rst_valid", W'(io_valid_0 | io_valid_1), '0);
      check_eq("rst_dout", io_dout_0 | io_dout_1, '0);
      // A read held through init must be ignored.
      io_req_0 = 1'b1; io_we_0 = 1'b0; io_addr_0 = 6'd10;
      reset = 1'b0;
      wait_init("boot");

      op1(0, 1'b0, 6'd10, '0, '0);
      blk_a = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      op1(0, 1'b1, 6'd5, blk_a, 4'b1111);
      op1(1, 1'b0, 6'd5, '0, '0);
      op1(0, 1'b1, 6'd5, {32'h0, 32'hDEAD_BEEF, 64'h0}, 4'b0100);
      op1(1, 1'b0, 6'd5, '0, '0);
      check_eq("merge_pattern", model[5],
               {32'h4444_4444, 32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111});

      blk_a = {4{32'hAAAA_0001}};
      blk_b = {4{32'hBBBB_0002}};
      op2(1'b1, 1'b1, 6'd7, blk_a, 4'b1111, 1'b1, 1'b1, 6'd7, blk_b, 4'b1111);
      op1(1, 1'b0, 6'd7, '0, '0);
      op2(1'b1, 1'b1, 6'd8, blk_b, 4'b1111, 1'b1, 1'b0, 6'd8, '0, '0);
      op2(1'b1, 1'b0, 6'd8, '0, '0, 1'b1, 1'b0, 6'd8, '0, '0);
      op2(1'b1, 1'b1, 6'd11, blk_a, 4'b0011, 1'b1, 1'b1, 6'd12, blk_b, 4'b1001);
      op2(1'b1, 1'b0, 6'd11, '0, '0, 1'b1, 1'b0, 6'd12, '0, '0);
      op1(1, 1'b1, 6'd8, blk_a, 4'b0000);
      op1(0, 1'b0, 6'd8, '0, '0);
      op2(1'b1, 1'b1, 6'd63, blk_a, 4'b1111, 1'b1, 1'b1, 6'd0, blk_b, 4'b0010);
      op2(1'b1, 1'b0, 6'd0, '0, '0, 1'b1, 1'b0, 6'd63, '0, '0);

`ifdef SRAM_PARITY_EN
      io_perr_inject = 1'b1;
      op1(0, 1'b1, 6'd9, blk_b, 4'b1111);
      io_perr_inject = 1'b0;
      op1(0, 1'b0, 6'd9, '0, '0);
      check_eq("perr_injected", W'(io_perr_0), W'(4'b0001));
      op1(1, 1'b0, 6'd5, '0, '0);
      check_eq("perr_clean", W'(io_perr_1), '0);
`endif

      for (int i = 0; i < 80; i++) begin
         r0 = 1'($urandom_range(0, 1)); w0 = 1'($urandom_range(0, 1));
         r1 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
         a0 = LG'($urandom_range(0, 7)); a1 = LG'($urandom_range(0, 7));
         m0 = E'($urandom_range(0, 15)); m1 = E'($urandom_range(0, 15));
         blk_a = {$urandom(), $urandom(), $urandom(), $urandom()};
         blk_b = {$urandom(), $urandom(), $urandom(), $urandom()};
         op2(r0, w0, a0, blk_a, m0, r1, w1, a1, blk_b, m1);
      end

      // Reset in the middle of a merge: the pending merge must be lost.
      op1(0, 1'b1, 6'd3, {4{32'h1234_5678}}, 4'b1111);
      io_req_0 = 1'b1; io_we_0 = 1'b1; io_addr_0 = 6'd3;
      io_din_0 = {4{32'hFFFF_0000}}; io_wmask_0 = 4'b0110;
      @(posedge clk);
      @(negedge clk);
      io_req_0 = 1'b0;
      check_eq("mid_merge_ready", W'(io_ready_0), '0);
      reset = 1'b1;
      #1;
      check_eq("mid_merge_rst_done", W'(io_init_done), '0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      wait_init("rerun");
      op1(1, 1'b0, 6'd3, '0, '0);
      op1(0, 1'b0, 6'd5, '0, '0);

      repeat (3) @(negedge clk);
      check_eq("q0_drained", W'(exp_q0.size()), '0);
      check_eq("q1_drained", W'(exp_q1.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
